// File: rtl/blake2_msg_feeder.sv
// Byte-stream feeder for the blake2 core load port: splits the upstream stream into
// BB-byte blocks, prepends the zero-padded key block, zero-pads the tail, and waits out the digest burst.
module blake2_msg_feeder #(
  parameter int BB    = 64,
  parameter int IDX_W = 6,
  parameter int KN_W  = 6,
  parameter int LL_W  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [KN_W-1:0]  kk_i,
  input  logic [KN_W-1:0]  nn_i,
  input  logic             slow_i,
  input  logic             empty_i,
  input  logic             in_v_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  input  logic             core_ready_i,
  input  logic             core_h_v_i,
  output logic             data_v_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       data_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic             slow_output_o,
  output logic [KN_W-1:0]  kk_o,
  output logic [KN_W-1:0]  nn_o,
  output logic [LL_W-1:0]  ll_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_KPAD,
    S_MSG,
    S_PAD,
    S_WAIT_H,
    S_WAIT_END
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BB - 1);
  localparam logic [KN_W-1:0]  KN_ONE  = KN_W'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [LL_W-1:0]  r_ll;
  logic             r_first;
  logic [KN_W-1:0]  r_kk;
  logic [KN_W-1:0]  r_nn;
  logic [KN_W-1:0]  r_keyCnt;
  logic             r_slow;
  logic             r_empty;
  logic             w_byteAvail;
  logic             w_send;
  logic             w_idxWrap;
  logic             w_keyDone;
  logic             w_start;

  assign w_start   = (r_state == S_IDLE) && start_i;
  assign w_idxWrap = (r_idx == IDX_MAX);
  assign w_keyDone = ((r_keyCnt + KN_ONE) == r_kk);

  // Upstream-sourced states need a valid byte; padding states always have a zero ready.
  always_comb begin
    w_byteAvail = 1'b0;
    case (r_state)
      S_KEY, S_MSG:  w_byteAvail = in_v_i;
      S_KPAD, S_PAD: w_byteAvail = 1'b1;
      default:       w_byteAvail = 1'b0;
    endcase
  end

  assign w_send = w_byteAvail & core_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    in_ready_o   = 1'b0;
    data_o       = 8'h00;
    block_last_o = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (kk_i != '0) begin
            w_nextState = S_KEY;
          end else if (empty_i) begin
            w_nextState = S_PAD;
          end else begin
            w_nextState = S_MSG;
          end
        end
      end
      S_KEY: begin
        in_ready_o   = core_ready_i;
        data_o       = in_data_i;
        block_last_o = r_empty;
        if (w_send && w_keyDone) begin
          if (!w_idxWrap) begin
            w_nextState = S_KPAD;
          end else begin
            w_nextState = r_empty ? S_WAIT_H : S_MSG;
          end
        end
      end
      S_KPAD: begin
        block_last_o = r_empty;
        if (w_send && w_idxWrap) begin
          w_nextState = r_empty ? S_WAIT_H : S_MSG;
        end
      end
      S_MSG: begin
        in_ready_o   = core_ready_i;
        data_o       = in_data_i;
        block_last_o = in_last_i;
        if (w_send && in_last_i) begin
          w_nextState = w_idxWrap ? S_WAIT_H : S_PAD;
        end
      end
      S_PAD: begin
        block_last_o = 1'b1;
        if (w_send && w_idxWrap) begin
          w_nextState = S_WAIT_H;
        end
      end
      S_WAIT_H: begin
        block_last_o = 1'b1;
        if (core_h_v_i) begin
          w_nextState = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        block_last_o = 1'b1;
        if (!core_h_v_i) begin
          done_o      = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // ll already counts the key block at start; only message bytes add to it afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_ll     <= '0;
      r_first  <= 1'b0;
      r_kk     <= '0;
      r_nn     <= '0;
      r_keyCnt <= '0;
      r_slow   <= 1'b0;
      r_empty  <= 1'b0;
    end else if (w_start) begin
      r_kk     <= kk_i;
      r_nn     <= nn_i;
      r_slow   <= slow_i;
      r_empty  <= empty_i;
      r_ll     <= (kk_i != '0) ? LL_W'(BB) : '0;
      r_idx    <= '0;
      r_first  <= 1'b1;
      r_keyCnt <= '0;
    end else if (w_send) begin
      r_idx <= w_idxWrap ? '0 : r_idx + IDX_W'(1);
      if (w_idxWrap) begin
        r_first <= 1'b0;
      end
      if (r_state == S_KEY) begin
        r_keyCnt <= r_keyCnt + KN_ONE;
      end
      if (r_state == S_MSG) begin
        r_ll <= r_ll + LL_W'(1);
      end
    end
  end

  assign data_v_o      = w_send;
  assign data_idx_o    = r_idx;
  assign block_first_o = r_first;
  assign slow_output_o = r_slow;
  assign kk_o          = r_kk;
  assign nn_o          = r_nn;
  assign ll_o          = r_ll;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Randomized bench for blake2_msg_feeder: a queue-based model builds the expected
// padded block stream per hash, and a small core model answers with a digest burst.
module tb_blake2_msg_feeder;

  localparam int BB    = 64;
  localparam int IDX_W = 6;
  localparam int KN_W  = 6;
  localparam int LL_W  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i;
  logic [KN_W-1:0]  kk_i;
  logic [KN_W-1:0]  nn_i;
  logic             slow_i;
  logic             empty_i;
  logic             in_v_i;
  logic             in_ready_o;
  logic [7:0]       in_data_i;
  logic             in_last_i;
  logic             core_ready_i;
  logic             core_h_v_i;
  logic             data_v_o;
  logic [IDX_W-1:0] data_idx_o;
  logic [7:0]       data_o;
  logic             block_first_o;
  logic             block_last_o;
  logic             slow_output_o;
  logic [KN_W-1:0]  kk_o;
  logic [KN_W-1:0]  nn_o;
  logic [LL_W-1:0]  ll_o;
  logic             busy_o;
  logic             done_o;

  int assertCount = 0;
  int failCount   = 0;

  byte unsigned gKey[$];
  byte unsigned gMsg[$];

  always #5 clk = ~clk;

  blake2_msg_feeder #(.BB(BB), .IDX_W(IDX_W), .KN_W(KN_W), .LL_W(LL_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .kk_i         (kk_i),
    .nn_i         (nn_i),
    .slow_i       (slow_i),
    .empty_i      (empty_i),
    .in_v_i       (in_v_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .core_ready_i (core_ready_i),
    .core_h_v_i   (core_h_v_i),
    .data_v_o     (data_v_o),
    .data_idx_o   (data_idx_o),
    .data_o       (data_o),
    .block_first_o(block_first_o),
    .block_last_o (block_last_o),
    .slow_output_o(slow_output_o),
    .kk_o         (kk_o),
    .nn_o         (nn_o),
    .ll_o         (ll_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic fillKey(input int n);
    gKey.delete();
    for (int i = 0; i < n; i++) gKey.push_back(8'($urandom));
  endtask

  task automatic fillMsg(input int n);
    gMsg.delete();
    for (int i = 0; i < n; i++) gMsg.push_back(8'($urandom));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},    busy_o,        1'b0);
    checkOutput({tag, "_inReady"}, in_ready_o,    1'b0);
    checkOutput({tag, "_dataV"},   data_v_o,      1'b0);
    checkOutput({tag, "_first"},   block_first_o, 1'b0);
    checkOutput({tag, "_last"},    block_last_o,  1'b0);
    checkOutput({tag, "_done"},    done_o,        1'b0);
    checkOutput({tag, "_idx"},     data_idx_o,    '0);
    checkOutput({tag, "_ll"},      ll_o,          '0);
    checkOutput({tag, "_kk"},      kk_o,          '0);
    checkOutput({tag, "_nn"},      nn_o,          '0);
    checkOutput({tag, "_slow"},    slow_output_o, 1'b0);
  endtask

  // One complete hash: key from gKey, message from gMsg. kind: 0 key/key-pad, 1 msg, 2 last msg, 3 tail pad.
  task automatic applyStimulus(input int kk, input int nn, input bit slow, input bit stallMode);
    byte unsigned up[$];
    byte unsigned expData[$];
    int           kind[$];
    int           msgLen, total, upPtr, sent, hvPhase, hvDelay, hvLen, dones;
    bit           empty, finished;
    logic [63:0]  expLL;
    msgLen   = gMsg.size();
    empty    = (msgLen == 0);
    upPtr    = 0;
    sent     = 0;
    hvPhase  = 0;
    hvDelay  = 0;
    hvLen    = 0;
    dones    = 0;
    finished = 1'b0;
    foreach (gKey[i]) up.push_back(gKey[i]);
    foreach (gMsg[i]) up.push_back(gMsg[i]);
    if (kk > 0) begin
      foreach (gKey[i]) begin expData.push_back(gKey[i]); kind.push_back(0); end
      while (expData.size() < BB) begin expData.push_back(8'h00); kind.push_back(0); end
    end
    foreach (gMsg[i]) begin
      expData.push_back(gMsg[i]);
      kind.push_back((i == msgLen - 1) ? 2 : 1);
    end
    while ((expData.size() % BB) != 0 || expData.size() == 0) begin
      expData.push_back(8'h00);
      kind.push_back(3);
    end
    total = expData.size();
    expLL = 64'((kk > 0) ? BB : 0) + 64'(msgLen);

    @(posedge clk); #1;
    kk_i    = KN_W'(kk);
    nn_i    = KN_W'(nn);
    slow_i  = slow;
    empty_i = empty;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    kk_i    = KN_W'($urandom);
    nn_i    = KN_W'($urandom);
    slow_i  = ~slow;
    empty_i = ~empty;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (stallMode) begin
        core_ready_i = !(cyc >= 30 && cyc < 35);
        in_v_i       = (upPtr < up.size());
      end else begin
        core_ready_i = ($urandom_range(0, 4) != 0);
        in_v_i       = (upPtr < up.size()) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      end
      in_data_i = (upPtr < up.size()) ? up[upPtr] : 8'($urandom);
      in_last_i = (upPtr < kk) ? 1'($urandom) : (upPtr == up.size() - 1);
      if (hvPhase == 1) begin
        if (hvDelay == 0) begin core_h_v_i = 1'b1; hvPhase = 2; end
        else hvDelay--;
      end else if (hvPhase == 2) begin
        if (hvLen == 0) begin core_h_v_i = 1'b0; hvPhase = 3; end
        else hvLen--;
      end

      @(negedge clk);
      if (done_o) dones++;
      if (hvPhase == 1 || hvPhase == 2) begin
        checkOutput("holdLL",   ll_o,          expLL);
        checkOutput("holdLast", block_last_o,  1'b1);
        checkOutput("holdKK",   kk_o,          64'(kk));
        checkOutput("holdNN",   nn_o,          64'(nn));
        checkOutput("holdSlow", slow_output_o, slow);
        checkOutput("doneEarly", done_o,       1'b0);
      end else if (hvPhase == 3) begin
        checkOutput("donePulse", done_o, 1'b1);
        hvPhase = 4;
      end else if (hvPhase == 4) begin
        checkOutput("doneOnce", done_o, 1'b0);
        checkOutput("idleBusy", busy_o, 1'b0);
        finished = 1'b1;
      end
      if (!core_ready_i) begin
        checkOutput("stallDataV",   data_v_o,   1'b0);
        checkOutput("stallInReady", in_ready_o, 1'b0);
      end
      if (data_v_o) begin
        if (sent < total) begin
          checkOutput("data",  data_o,        expData[sent]);
          checkOutput("idx",   data_idx_o,    64'(sent % BB));
          checkOutput("first", block_first_o, (sent < BB));
          if (sent < total - BB) checkOutput("lastLow", block_last_o, 1'b0);
          else if (kind[sent] != 1) checkOutput("lastHigh", block_last_o, 1'b1);
          sent++;
          if (sent == total) begin
            hvPhase = 1;
            hvDelay = $urandom_range(0, 3);
            hvLen   = slow ? 2 * nn : nn;
          end
        end else begin
          checkOutput("extraByte", 1'b1, 1'b0);
        end
      end
      if (in_v_i && in_ready_o) begin
        if (upPtr < up.size()) upPtr++;
        else checkOutput("overConsume", 1'b1, 1'b0);
      end
      @(posedge clk); #1;
    end

    checkOutput("finished",  finished, 1'b1);
    checkOutput("bytesSent", 64'(sent),  64'(total));
    checkOutput("consumed",  64'(upPtr), 64'(up.size()));
    checkOutput("doneCount", 64'(dones), 64'd1);
    in_v_i       = 1'b0;
    core_ready_i = 1'b0;
    core_h_v_i   = 1'b0;
  endtask

  // Abort a keyed hash in the second block at idx 20 and confirm the feeder returns to a clean idle.
  task automatic applyResetMidHash();
    bit hit;
    hit = 1'b0;
    @(posedge clk); #1;
    kk_i    = 6'd8;
    nn_i    = 6'd32;
    slow_i  = 1'b1;
    empty_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i      = 1'b0;
    in_v_i       = 1'b1;
    core_ready_i = 1'b1;
    in_data_i    = 8'hA5;
    in_last_i    = 1'b0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge clk);
      if (in_ready_o && !block_first_o && data_idx_o == 6'd20) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("reachMsgIdx20", hit, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midReset");
    @(posedge clk); #1;
    in_v_i       = 1'b0;
    core_ready_i = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    kk_i         = '0;
    nn_i         = '0;
    slow_i       = 1'b0;
    empty_i      = 1'b0;
    in_v_i       = 1'b1;
    in_data_i    = 8'h5A;
    in_last_i    = 1'b0;
    core_ready_i = 1'b1;
    core_h_v_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1;
    reset        = 1'b0;
    in_v_i       = 1'b0;
    core_ready_i = 1'b0;

    gKey.delete();
    gMsg = '{8'h61, 8'h62, 8'h63};
    applyStimulus(0, 32, 1'b0, 1'b0);

    gMsg.delete();
    applyStimulus(0, 32, 1'b0, 1'b0);

    fillMsg(64);
    applyStimulus(0, 32, 1'b0, 1'b0);

    fillKey(32);
    fillMsg(65);
    applyStimulus(32, 32, 1'b1, 1'b0);

    gKey.delete();
    fillMsg(100);
    applyStimulus(0, 16, 1'b0, 1'b1);

    applyResetMidHash();
    fillKey(8);
    fillMsg(20);
    applyStimulus(8, 32, 1'b1, 1'b0);

    fillKey(16);
    gMsg.delete();
    applyStimulus(16, 20, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int k;
      k = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 32);
      fillKey(k);
      fillMsg($urandom_range(0, 150));
      applyStimulus(k, $urandom_range(1, 32), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
